// File: rtl/lane_rr_scheduler_pkg.sv
// Shared constants and types for the four-lane round-robin byte scheduler.
package lane_rr_scheduler_pkg;

    localparam int unsigned NumLanes = 4;
    localparam int unsigned LaneW    = 2;

    typedef logic [LaneW-1:0] lane_t;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

endpackage

// File: rtl/lane_rr_scheduler_if.sv
// Lane-side and stream-side signals of the scheduler, with producer (master) and
// scheduler (slave) views.
interface lane_rr_scheduler_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0]                        in0;
    logic [WIDTH-1:0]                        in1;
    logic [WIDTH-1:0]                        in2;
    logic [WIDTH-1:0]                        in3;
    logic [lane_rr_scheduler_pkg::NumLanes-1:0] valid;
    logic [lane_rr_scheduler_pkg::NumLanes-1:0] ready;
    logic [WIDTH-1:0]                        out;
    logic                                    validout;
    logic                                    out_ready;
    logic [lane_rr_scheduler_pkg::LaneW-1:0]    sel;
    logic [lane_rr_scheduler_pkg::NumLanes-1:0] err_ovf;

    modport master (
        output in0, in1, in2, in3, valid, out_ready,
        input  ready, out, validout, sel, err_ovf
    );

    modport slave (
        input  in0, in1, in2, in3, valid, out_ready,
        output ready, out, validout, sel, err_ovf
    );
endinterface

// File: rtl/lane_fifo2.sv
// Two-entry FIFO used as the per-lane buffer; push when full and pop when empty are ignored.
module lane_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q, rd_q;
    logic [1:0]       cnt_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= din;
                wr_q        <= ~wr_q;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/lane_rr_scheduler.sv
// Merges four byte lanes into one stream: round-robin grants with bursts of up to
// BURST_MAX bytes into a registered, back-pressurable output stage.
module lane_rr_scheduler
    import lane_rr_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input logic                clk,
    input logic                rst_n,
    lane_rr_scheduler_if.slave bus
);
    localparam int unsigned        BurstW    = $clog2(BURST_MAX + 1);
    localparam logic [BurstW-1:0]  BurstMaxW = BurstW'(BURST_MAX);

    logic [WIDTH-1:0]    lane_in   [NumLanes];
    logic [WIDTH-1:0]    lane_head [NumLanes];
    logic [1:0]          lane_cnt  [NumLanes];
    logic [NumLanes-1:0] empty, full, push, pop, ready;

    state_e              state_q;
    lane_t               cur_q, sel_q;
    logic [BurstW-1:0]   burst_q;
    logic [WIDTH-1:0]    out_q;
    logic                validout_q;
    logic [NumLanes-1:0] err_q;
    logic                rdy_en_q;

    lane_t               load_lane, cand;
    logic                have_lane, load_opp, load;

    assign lane_in[0] = bus.in0;
    assign lane_in[1] = bus.in1;
    assign lane_in[2] = bus.in2;
    assign lane_in[3] = bus.in3;

    for (genvar i = 0; i < NumLanes; i++) begin : g_lane
        // rdy_en_q holds ready low for the whole reset period and the first cycle after it.
        assign ready[i] = rdy_en_q && (lane_cnt[i] < 2'd2);
        assign push[i]  = bus.valid[i] && ready[i] && !full[i];
        assign pop[i]   = load && (load_lane == lane_t'(i));

        lane_fifo2 #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (push[i]),
            .pop  (pop[i]),
            .din  (lane_in[i]),
            .dout (lane_head[i]),
            .empty(empty[i]),
            .full (full[i]),
            .count(lane_cnt[i])
        );
    end

    always_comb begin
        load_lane = cur_q;
        have_lane = 1'b0;
        cand      = cur_q;
        if (state_q == StGrant && !empty[cur_q] && burst_q < BurstMaxW) begin
            have_lane = 1'b1;
        end else begin
            // Scan cur+1 .. cur+4; the final step wraps back onto cur itself.
            for (int k = 1; k <= NumLanes; k++) begin
                cand = cur_q + lane_t'(k);
                if (!have_lane && !empty[cand]) begin
                    load_lane = cand;
                    have_lane = 1'b1;
                end
            end
        end
    end

    assign load_opp = !validout_q || bus.out_ready;
    assign load     = load_opp && have_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_q      <= lane_t'(NumLanes - 1);
            burst_q    <= '0;
            out_q      <= '0;
            sel_q      <= '0;
            validout_q <= 1'b0;
            err_q      <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= err_q | (bus.valid & ~ready);
            if (load) begin
                out_q      <= lane_head[load_lane];
                sel_q      <= load_lane;
                validout_q <= 1'b1;
                state_q    <= StGrant;
                if (state_q == StGrant && load_lane == cur_q) begin
                    if (burst_q != BurstMaxW) burst_q <= burst_q + 1'b1;
                end else begin
                    cur_q   <= load_lane;
                    burst_q <= BurstW'(1);
                end
            end else if (load_opp) begin
                validout_q <= 1'b0;
                state_q    <= StIdle;
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.out      = out_q;
    assign bus.sel      = sel_q;
    assign bus.validout = validout_q;
    assign bus.err_ovf  = err_q;
endmodule
